rst_seq_ctrl: RTL and testbench
===============================

Name: rst_seq_ctrl

Overview:
- Always-on sequencer that releases NUM_DOMAINS clock-stoppable reset domains one at a time, in index order.
- For each domain it drives `deassert[i]`, then waits until that domain's synchronizer reports its reset released (`dom_rst[i]` low).
- Supports a timeout with error reporting, and a per-domain software re-reset after the full sequence completes.
- Runs on the always-on clock that feeds the per-domain reset synchronizers.

Parameters:
- NUM_DOMAINS, 4: number of sequenced domains (2..16).
- IDX_W, 2: width of domain index; must satisfy 2^IDX_W >= NUM_DOMAINS.
- GAP_CYCLES, 16: idle clk cycles between one domain's ack and the next domain's deassert (>=1).
- TIMEOUT_CYCLES, 1024: maximum WAIT_ACK cycles per domain (>=4).
- PULSE_CYCLES, 8: length of the re-reset assertion (>=1).
- CNT_W, 11: width of the shared down-counter; must hold max(GAP_CYCLES, TIMEOUT_CYCLES, PULSE_CYCLES).

Ports:
- clk, input, 1: always-on clock.
- rst_async, input, 1: reset, asynchronous, active-high.
- start, input, 1: one-cycle pulse; begins the sequence, or retries after an error.
- dom_rst, input, NUM_DOMAINS: per-domain reset-status outputs of the synchronizers; treated as asynchronous.
- rerst_req, input, 1: one-cycle pulse requesting re-reset of domain rerst_idx.
- rerst_idx, input, IDX_W: target domain for rerst_req.
- deassert, output, NUM_DOMAINS: per-domain reset-release request; registered.
- dom_rst_async, output, NUM_DOMAINS: per-domain forced reset; registered; ORed externally into that domain's rst_async.
- busy, output, 1: high in any state other than IDLE, DONE or ERROR.
- done, output, 1: high in DONE.
- err, output, 1: high in ERROR.
- err_dom, output, IDX_W: index of the domain that timed out; valid while err is high.

Behaviour:
- Reset values:
  - state = IDLE.
  - deassert = 0, dom_rst_async = 0.
  - busy = 0, done = 0, err = 0, err_dom = 0.
  - idx = 0, counter = 0, single-domain mode flag = 0.
  - Ack synchronizer flops reset to all 1.
- Ack synchronization:
  - `dom_rst` passes through a 2-flop synchronizer, giving `ack_n`.
  - Domain i is acknowledged when `ack_n[i] == 0`.
- All outputs are registered and reflect the state entered at the same edge.
- State machine:
  - IDLE:
    - start -> DEASSERT with idx = 0.
    - rerst_req is ignored.
  - DEASSERT (1 cycle):
    - Set deassert[idx] = 1. It is sticky: cleared only by rst_async or a re-reset.
    - Load counter = TIMEOUT_CYCLES-1.
    - -> WAIT_ACK.
  - WAIT_ACK, evaluated in this priority order:
    1. If ack: in single mode -> DONE; else if idx == NUM_DOMAINS-1 -> DONE; else load counter = GAP_CYCLES-1 and -> GAP.
    2. Else if counter == 0: -> ERROR, err_dom = idx.
    3. Else counter decrements.
    - Ack beats timeout when both occur in the same cycle.
  - GAP:
    - Counter decrements.
    - At 0: idx++ and -> DEASSERT.
  - DONE:
    - rerst_req with rerst_idx < NUM_DOMAINS: clear deassert[rerst_idx], set dom_rst_async[rerst_idx] = 1, idx = rerst_idx, set single mode, load counter = PULSE_CYCLES-1, -> RERST.
    - rerst_idx >= NUM_DOMAINS is ignored; state stays DONE.
    - start is ignored.
  - RERST:
    - Counter decrements.
    - At 0: clear dom_rst_async[idx] and -> RERST_WAIT.
  - RERST_WAIT:
    - Waits until the synchronized status shows domain idx in reset (`ack_n[idx] == 1`), then -> DEASSERT.
    - This wait has no timeout.
    - Single mode is cleared on entry to DONE.
  - ERROR:
    - err = 1; deasserts already granted stay high.
    - start -> DEASSERT with the same idx (retry); err clears on that edge.
  - Illegal state encodings -> IDLE.
- Handshake: start and rerst_req are level-sampled every cycle; in states where they are not legal they are ignored, not queued.
- Latency (all ack times are clk edges after dom_rst[i] falls):
  - start sampled at edge 0 -> state DEASSERT after edge 0 -> deassert[0] = 1 and state WAIT_ACK after edge 1.
  - Ack of domain i is visible 2 edges after dom_rst[i] falls; the state leaves WAIT_ACK on edge 3.
  - deassert[i+1] rises GAP_CYCLES+1 edges after WAIT_ACK exits.
- rst_async mid-sequence: everything returns to its reset values immediately, including dropping all deasserts.

Decomposition:
- Shared package rst_ctrl_pkg holds:
  - one-hot state localparams: IDLE, DEASSERT, WAIT_ACK, GAP, DONE, RERST, RERST_WAIT, ERROR;
  - state-name strings for simulation-only debug.
- One sub-module, sync_2ff (parameterized width, async set to 1), used for the dom_rst synchronizer.
- Counter and FSM stay in the top module.

Test Plan:
- Nominal sequence, NUM_DOMAINS=4, GAP_CYCLES=16, each dom_rst[i] falls 5 cycles after deassert[i] rises -> deassert bits rise in order 0,1,2,3; the gap between each ack-exit and the next deassert is exactly 17 edges; done=1, busy=0 at the end.
- Timeout, TIMEOUT_CYCLES=8, dom_rst[2] held high -> err=1, err_dom=2 exactly 8 cycles after entering WAIT_ACK; deassert = 4'b0011 plus bit 2 = 4'b0111. Then drop dom_rst[2] and pulse start -> retry succeeds, sequence finishes with done=1.
- Ack and timeout on the same cycle (ack_n[idx] low exactly when counter == 0) -> no error; sequence proceeds to GAP.
- Re-reset in DONE, rerst_idx=1, PULSE_CYCLES=8 -> deassert[1] drops; dom_rst_async[1] is high for exactly 8 cycles; after dom_rst[1] is seen high then low, deassert[1] reasserts, state returns to DONE, and the other deassert bits are unchanged.
- Ignored inputs: start while busy, rerst_req in IDLE, rerst_idx=5 with NUM_DOMAINS=4 -> no state or output change.
- rst_async pulsed during GAP after domain 1 -> all outputs return to their reset values within the same cycle; a new start reruns the full sequence from domain 0.

Source files
------------

// File: rtl/rst_ctrl_pkg.sv
// Shared definitions for the reset sequencer: one-hot state encodings and a
// simulation-only helper that turns a state into a readable name.
package rst_ctrl_pkg;

    localparam int unsigned STATE_W = 8;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t IDLE       = 8'b0000_0001;
    localparam state_t DEASSERT   = 8'b0000_0010;
    localparam state_t WAIT_ACK   = 8'b0000_0100;
    localparam state_t GAP        = 8'b0000_1000;
    localparam state_t DONE       = 8'b0001_0000;
    localparam state_t RERST      = 8'b0010_0000;
    localparam state_t RERST_WAIT = 8'b0100_0000;
    localparam state_t ERROR      = 8'b1000_0000;

    function automatic string state_name(input state_t s);
        case (s)
            IDLE:       return "IDLE";
            DEASSERT:   return "DEASSERT";
            WAIT_ACK:   return "WAIT_ACK";
            GAP:        return "GAP";
            DONE:       return "DONE";
            RERST:      return "RERST";
            RERST_WAIT: return "RERST_WAIT";
            ERROR:      return "ERROR";
            default:    return "ILLEGAL";
        endcase
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer; both stages preset to 1 so a domain reads as "in reset"
// until its real status has crossed over.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_async,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Always-on reset sequencer: releases reset domains one at a time in index order,
// with ack timeout, retry after error and per-domain software re-reset.
module rst_seq_ctrl
    import rst_ctrl_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS    = 4,
    parameter int unsigned IDX_W          = 2,
    parameter int unsigned GAP_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned PULSE_CYCLES   = 8,
    parameter int unsigned CNT_W          = 11
) (
    input  logic                   clk,
    input  logic                   rst_async,
    input  logic                   start,
    input  logic [NUM_DOMAINS-1:0] dom_rst,
    input  logic                   rerst_req,
    input  logic [IDX_W-1:0]       rerst_idx,
    output logic [NUM_DOMAINS-1:0] deassert,
    output logic [NUM_DOMAINS-1:0] dom_rst_async,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [IDX_W-1:0]       err_dom
);

    localparam logic [CNT_W-1:0] TMO_LOAD   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DOMAINS - 1);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   single_q, single_d;
    logic [NUM_DOMAINS-1:0] deassert_q, deassert_d;
    logic [NUM_DOMAINS-1:0] force_q, force_d;
    logic [IDX_W-1:0]       err_dom_q, err_dom_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic [NUM_DOMAINS-1:0] ack_n;
    logic [NUM_DOMAINS-1:0] idx_mask;
    logic [NUM_DOMAINS-1:0] rerst_mask;
    logic                   ack;
    logic                   in_reset;
    logic                   rerst_valid;

    sync_2ff #(
        .WIDTH (NUM_DOMAINS)
    ) u_ack_sync (
        .clk       (clk),
        .rst_async (rst_async),
        .d         (dom_rst),
        .q         (ack_n)
    );

    // Masks instead of variable bit-selects keep the index width independent of NUM_DOMAINS.
    assign idx_mask    = NUM_DOMAINS'(1) << idx_q;
    assign rerst_mask  = NUM_DOMAINS'(1) << rerst_idx;
    assign ack         = ~|(ack_n & idx_mask);
    assign in_reset    = |(ack_n & idx_mask);
    assign rerst_valid = (32'(rerst_idx) < NUM_DOMAINS);

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            single_q   <= 1'b0;
            deassert_q <= '0;
            force_q    <= '0;
            err_dom_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            single_q   <= single_d;
            deassert_q <= deassert_d;
            force_q    <= force_d;
            err_dom_q  <= err_dom_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        single_d   = single_q;
        deassert_d = deassert_q;
        force_d    = force_q;
        err_dom_d  = err_dom_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    state_d = DEASSERT;
                end
            end
            DEASSERT: begin
                deassert_d = deassert_q | idx_mask;
                cnt_d      = TMO_LOAD;
                state_d    = WAIT_ACK;
            end
            WAIT_ACK: begin
                // An ack arriving on the last timeout cycle still counts.
                if (ack) begin
                    if (single_q || idx_q == LAST_IDX) begin
                        single_d = 1'b0;
                        state_d  = DONE;
                    end else begin
                        cnt_d   = GAP_LOAD;
                        state_d = GAP;
                    end
                end else if (cnt_q == '0) begin
                    err_dom_d = idx_q;
                    state_d   = ERROR;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = DEASSERT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (rerst_req && rerst_valid) begin
                    deassert_d = deassert_q & ~rerst_mask;
                    force_d    = force_q | rerst_mask;
                    idx_d      = rerst_idx;
                    single_d   = 1'b1;
                    cnt_d      = PULSE_LOAD;
                    state_d    = RERST;
                end
            end
            RERST: begin
                if (cnt_q == '0) begin
                    force_d = force_q & ~idx_mask;
                    state_d = RERST_WAIT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RERST_WAIT: begin
                // Release only once the domain has visibly gone back into reset.
                if (in_reset) begin
                    state_d = DEASSERT;
                end
            end
            ERROR: begin
                if (start) begin
                    state_d = DEASSERT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy_d = (state_d != IDLE) && (state_d != DONE) && (state_d != ERROR);
        done_d = (state_d == DONE);
        err_d  = (state_d == ERROR);
    end

    assign deassert      = deassert_q;
    assign dom_rst_async = force_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign err_dom       = err_dom_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: behavioural domain models drive dom_rst, an edge-count
// predictor supplies expected release times, plus a table of hand-computed runs.
module tb_rst_seq_ctrl;

    localparam int unsigned N     = 4;
    localparam int unsigned IW    = 3;
    localparam int unsigned GAP   = 16;
    localparam int unsigned TMO   = 8;
    localparam int unsigned PULSE = 8;

    typedef int dly_t[N];

    typedef struct {
        dly_t         d;
        bit           exp_err;
        int           exp_dom;
        logic [N-1:0] exp_dea;
        int           exp_end;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_async = 1'b1;
    logic          start = 1'b0;
    logic [N-1:0]  dom_rst = '1;
    logic          rerst_req = 1'b0;
    logic [IW-1:0] rerst_idx = '0;
    logic [N-1:0]  deassert;
    logic [N-1:0]  dom_rst_async;
    logic          busy;
    logic          done;
    logic          err;
    logic [IW-1:0] err_dom;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    dly_t dly = '{default: 255};
    dly_t rise = '{default: 0};
    bit   rose[N] = '{default: 1'b0};

    always #5 clk = ~clk;

    rst_seq_ctrl #(
        .NUM_DOMAINS    (N),
        .IDX_W          (IW),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO),
        .PULSE_CYCLES   (PULSE),
        .CNT_W          (11)
    ) dut (
        .clk           (clk),
        .rst_async     (rst_async),
        .start         (start),
        .dom_rst       (dom_rst),
        .rerst_req     (rerst_req),
        .rerst_idx     (rerst_idx),
        .deassert      (deassert),
        .dom_rst_async (dom_rst_async),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .err_dom       (err_dom)
    );

    // Each domain leaves reset dly[i] edges after its deassert rises; forced or
    // withdrawn release puts it straight back into reset.
    always begin
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (!deassert[i] || dom_rst_async[i]) begin
                rose[i]    = 1'b0;
                dom_rst[i] = 1'b1;
            end else if (!rose[i]) begin
                rose[i] = 1'b1;
                rise[i] = cyc;
            end
            if (rose[i] && (cyc - rise[i] >= dly[i])) dom_rst[i] = 1'b0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Release of domain i starts one edge after start (or after the previous gap);
    // the ack exits WAIT_ACK 3 edges after dom_rst falls, else timeout at TMO edges.
    function automatic void predict(input dly_t d, input int s, output dly_t pr,
                                    output int n, output int pend, output bit perr,
                                    output int pdom, output logic [N-1:0] pdea);
        int r;
        r    = s + 1;
        pr   = '{default: 0};
        n    = 0;
        pend = 0;
        perr = 1'b0;
        pdom = 0;
        pdea = '0;
        for (int i = 0; i < N; i++) begin
            pr[i]   = r;
            n       = i + 1;
            pdea[i] = 1'b1;
            if (d[i] + 3 > TMO) begin
                pend = r + TMO;
                perr = 1'b1;
                pdom = i;
                return;
            end
            pend = r + d[i] + 3;
            r    = pend + GAP + 1;
        end
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, " deassert"}, deassert, 0);
        check({tag, " dom_rst_async"}, dom_rst_async, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " err"}, err, 0);
        check({tag, " err_dom"}, err_dom, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_async = 1'b1;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_async = 1'b0;
    endtask

    task automatic pulse_start(output int s);
        @(negedge clk);
        start = 1'b1;
        s     = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_edge(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_end(output int e);
        e = -1;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            #2;
            if (done || err) begin
                e = cyc;
                break;
            end
        end
        if (e < 0) begin
            checks++;
            errors++;
            $display("FAIL end_wait: got no done/err, expected one within 400 cycles");
        end
    endtask

    task automatic run_seq(input dly_t d, input string tag, output int s, output int e);
        dly_t         pr;
        int           n, pend, pdom;
        bit           perr;
        logic [N-1:0] pdea;
        dly = d;
        pulse_start(s);
        wait_end(e);
        predict(d, s, pr, n, pend, perr, pdom, pdea);
        for (int i = 0; i < n; i++) check({tag, " rise"}, rise[i], pr[i]);
        check({tag, " end_edge"}, e, pend);
        check({tag, " err"}, err, int'(perr));
        check({tag, " done"}, done, int'(!perr));
        check({tag, " busy"}, busy, 0);
        check({tag, " deassert"}, deassert, pdea);
        if (perr) check({tag, " err_dom"}, err_dom, pdom);
    endtask

    initial begin
        vec_t tbl[5];
        int   s, e, s2, ev, hi;
        dly_t rd;

        tbl[0] = '{'{5, 5, 5, 5}, 1'b0, 0, 4'hf, 84};
        tbl[1] = '{'{0, 0, 0, 0}, 1'b0, 0, 4'hf, 64};
        tbl[2] = '{'{2, 7, 0, 0}, 1'b1, 1, 4'h3, 31};
        tbl[3] = '{'{5, 0, 4, 1}, 1'b0, 0, 4'hf, 74};
        tbl[4] = '{'{0, 0, 0, 6}, 1'b1, 3, 4'hf, 69};

        for (int k = 0; k < 5; k++) begin
            do_reset();
            run_seq(tbl[k].d, "tbl", s, e);
            check("tbl end_rel", e - s, tbl[k].exp_end);
            check("tbl err", err, int'(tbl[k].exp_err));
            check("tbl deassert", deassert, tbl[k].exp_dea);
            if (tbl[k].exp_err) check("tbl err_dom", err_dom, tbl[k].exp_dom);
        end

        // Timeout on domain 2, then retry once it acks.
        do_reset();
        run_seq('{1, 3, 255, 0}, "tmo", s, e);
        check("tmo window", e - rise[2], TMO);
        check("tmo deassert", deassert, 4'b0111);
        check("tmo err_dom", err_dom, 2);
        @(negedge clk);
        dly[2] = 0;
        repeat (4) @(negedge clk);
        pulse_start(s2);
        check("retry err_clear", err, 0);
        check("retry busy", busy, 1);
        wait_end(e);
        check("retry end_rel", e - s2, 22);
        check("retry rise3", rise[3] - s2, 19);
        check("retry done", done, 1);
        check("retry deassert", deassert, 4'hf);

        // Re-reset domain 1 from DONE.
        @(negedge clk);
        rerst_idx = 3'd1;
        rerst_req = 1'b1;
        ev        = cyc + 1;
        @(negedge clk);
        rerst_req = 1'b0;
        check("rerst deassert", deassert, 4'b1101);
        check("rerst force", dom_rst_async, 4'b0010);
        check("rerst busy", busy, 1);
        check("rerst done", done, 0);
        hi = 0;
        for (int k = 0; k < 12; k++) begin
            if (dom_rst_async[1]) hi++;
            @(posedge clk);
            #2;
        end
        check("rerst pulse_len", hi, PULSE);
        check("rerst rise1", rise[1] - ev, 10);
        wait_end(e);
        check("rerst end_rel", e - ev, 16);
        check("rerst done_back", done, 1);
        check("rerst deassert_back", deassert, 4'hf);
        check("rerst force_clear", dom_rst_async, 0);

        // Ignored in DONE: out-of-range re-reset and start.
        @(negedge clk);
        rerst_idx = 3'd5;
        rerst_req = 1'b1;
        @(negedge clk);
        rerst_req = 1'b0;
        repeat (3) @(negedge clk);
        check("ign idx5 done", done, 1);
        check("ign idx5 busy", busy, 0);
        check("ign idx5 deassert", deassert, 4'hf);
        check("ign idx5 force", dom_rst_async, 0);
        pulse_start(s);
        repeat (3) @(negedge clk);
        check("ign start_done done", done, 1);
        check("ign start_done busy", busy, 0);

        // Ignored in IDLE: re-reset request.
        do_reset();
        @(negedge clk);
        rerst_idx = 3'd1;
        rerst_req = 1'b1;
        @(negedge clk);
        rerst_req = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("ign idle");

        // Start while busy is ignored; async reset during the gap after domain 1.
        dly = '{2, 2, 2, 2};
        pulse_start(s);
        wait_edge(s + 8);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_edge(s + 30);
        check("busy_start rise0", rise[0] - s, 1);
        check("busy_start rise1", rise[1] - s, 23);
        check("gap deassert", deassert, 4'b0011);
        check("gap busy", busy, 1);
        @(negedge clk);
        rst_async = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_async = 1'b0;
        run_seq('{1, 1, 1, 1}, "rerun", s, e);
        check("rerun end_rel", e - s, 68);

        // Randomized delays against the predictor.
        for (int t = 0; t < 25; t++) begin
            do_reset();
            for (int i = 0; i < N; i++) rd[i] = int'($urandom_range(0, 7));
            run_seq(rd, "rand", s, e);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
